// File: rtl/usb_rx_unstuff_byte_pkg.sv
// Shared types and default sizes for the USB RX unstuff/byte-assembly slice.
// Optional feature macro used by this slice: USB_RX_BYTE_COUNT_EN.
package usb_rx_pkg;

    localparam int USB_BYTE_W    = 8;
    localparam int USB_STUFF_LEN = 6;
    localparam int USB_BCNT_W    = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RX   = 2'd1,
        ERR  = 2'd2,
        DONE = 2'd3
    } rx_state_t;

endpackage

// File: rtl/usb_rx_unstuff_byte_if.sv
// Bundle of the bit-stream inputs and the CRC/byte/status outputs of the
// unstuff stage. byte_count exists only when USB_RX_BYTE_COUNT_EN is defined.
interface usb_rx_unstuff_byte_if
    import usb_rx_pkg::*;
#(
    parameter int BYTE_W = USB_BYTE_W
`ifdef USB_RX_BYTE_COUNT_EN
   ,parameter int BCNT_W = USB_BCNT_W
`endif
);
    logic              rx_start;
    logic              bit_valid;
    logic              d_in;
    logic              eop;
    logic              crc_clear;
    logic              crc_shift_enable;
    logic              crc_serial_in;
    logic [BYTE_W-1:0] rx_byte;
    logic              byte_valid;
    logic              stuff_err;
    logic              align_err;
    logic              packet_done;
`ifdef USB_RX_BYTE_COUNT_EN
    logic [BCNT_W-1:0] byte_count;
`endif

    // Bit source side (line decoder / bench)
    modport master (
        output rx_start, bit_valid, d_in, eop,
        input  crc_clear, crc_shift_enable, crc_serial_in,
        input  rx_byte, byte_valid, stuff_err, align_err, packet_done
`ifdef USB_RX_BYTE_COUNT_EN
       ,input  byte_count
`endif
    );

    // Unstuff stage side
    modport slave (
        input  rx_start, bit_valid, d_in, eop,
        output crc_clear, crc_shift_enable, crc_serial_in,
        output rx_byte, byte_valid, stuff_err, align_err, packet_done
`ifdef USB_RX_BYTE_COUNT_EN
       ,output byte_count
`endif
    );

endinterface

// File: rtl/usb_rx_unstuff_byte_unstuff.sv
// Run-length tracker for bit stuffing: classifies each incoming bit as data,
// a dropped stuffed zero, or a stuffing violation. Classification is
// combinational; only the ones counter is stored here.
module usb_bit_unstuff
    import usb_rx_pkg::*;
#(
    parameter int STUFF_LEN = USB_STUFF_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic bit_en,
    input  logic d_in,
    output logic data_valid,
    output logic data_bit,
    output logic stuff_err
);

    localparam int OC_W = $clog2(STUFF_LEN + 1);

    logic [OC_W-1:0] ones_cnt_q, ones_cnt_d;
    logic            at_limit;

    assign at_limit = (ones_cnt_q == OC_W'(STUFF_LEN));

    // Classify the current bit and compute the next run length
    always_comb begin
        data_valid = bit_en && !at_limit;
        data_bit   = d_in;
        stuff_err  = bit_en && at_limit && d_in;
        ones_cnt_d = ones_cnt_q;
        if (clr) begin
            ones_cnt_d = '0;
        end else if (bit_en) begin
            if (at_limit) begin
                ones_cnt_d = '0;
            end else if (d_in) begin
                ones_cnt_d = ones_cnt_q + 1'b1;
            end else begin
                ones_cnt_d = '0;
            end
        end
    end

    // Run-length register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones_cnt_q <= '0;
        end else begin
            ones_cnt_q <= ones_cnt_d;
        end
    end

endmodule

// File: rtl/usb_rx_unstuff_byte.sv
// USB RX stage ahead of crc_16_gen: drops stuffed bits, feeds data bits to
// the CRC, assembles LSB-first bytes and reports packet end status.
// Optional macro USB_RX_BYTE_COUNT_EN adds a saturating per-packet byte count.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for rx_start, CRC held in clear
// RX    | receiving packet bits, data bits shifted into CRC and byte SR
// ERR   | stuffing violation seen, CRC frozen, waiting for eop
// DONE  | one cycle after clean/misaligned eop so the CRC can be sampled
module usb_rx_unstuff_byte
    import usb_rx_pkg::*;
#(
    parameter int BYTE_W    = USB_BYTE_W,
    parameter int STUFF_LEN = USB_STUFF_LEN
`ifdef USB_RX_BYTE_COUNT_EN
   ,parameter int BCNT_W    = USB_BCNT_W
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    usb_rx_unstuff_byte_if.slave   rx_if
);

    localparam int BIT_CNT_W = $clog2(BYTE_W);

    rx_state_t            state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]    sr_q, sr_d;
    logic [BYTE_W-1:0]    rx_byte_q, rx_byte_d;
    logic                 crc_clear_q, crc_clear_d;
    logic                 shift_q, shift_d;
    logic                 serial_q, serial_d;
    logic                 byte_valid_q, byte_valid_d;
    logic                 stuff_err_q, stuff_err_d;
    logic                 align_err_q, align_err_d;
    logic                 packet_done_q, packet_done_d;

    logic start;
    logic bit_en;
    logic data_valid;
    logic data_bit;
    logic stuff_hit;
    logic byte_done;

    // A restart is only honoured from IDLE or mid-packet; ERR/DONE finish first
    assign start     = rx_if.rx_start && ((state_q == IDLE) || (state_q == RX));
    assign bit_en    = rx_if.bit_valid && (state_q == RX) && !rx_if.rx_start;
    assign byte_done = data_valid && (bit_cnt_q == BIT_CNT_W'(BYTE_W - 1));

    usb_bit_unstuff #(
        .STUFF_LEN (STUFF_LEN)
    ) u_unstuff (
        .clk        (clk),
        .rst        (rst),
        .clr        (start),
        .bit_en     (bit_en),
        .d_in       (rx_if.d_in),
        .data_valid (data_valid),
        .data_bit   (data_bit),
        .stuff_err  (stuff_hit)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rx_if.rx_start) state_d = RX;
            end
            RX: begin
                if (rx_if.rx_start) begin
                    state_d = RX;
                end else if (stuff_hit) begin
                    // eop in the same cycle closes the errored packet at once
                    state_d = rx_if.eop ? IDLE : ERR;
                end else if (rx_if.eop) begin
                    state_d = DONE;
                end
            end
            ERR: begin
                if (rx_if.eop) state_d = IDLE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values; the bit is applied before eop is judged
    always_comb begin
        bit_cnt_d     = bit_cnt_q;
        sr_d          = sr_q;
        rx_byte_d     = rx_byte_q;
        shift_d       = 1'b0;
        serial_d      = 1'b0;
        byte_valid_d  = 1'b0;
        stuff_err_d   = stuff_hit;
        align_err_d   = 1'b0;
        packet_done_d = 1'b0;
        crc_clear_d   = (state_d == IDLE) || ((state_q == RX) && rx_if.rx_start);

        if (start) begin
            bit_cnt_d = '0;
            sr_d      = '0;
        end else if (data_valid) begin
            sr_d      = {data_bit, sr_q[BYTE_W-1:1]};
            shift_d   = 1'b1;
            serial_d  = data_bit;
            bit_cnt_d = byte_done ? '0 : bit_cnt_q + 1'b1;
            if (byte_done) begin
                rx_byte_d    = sr_d;
                byte_valid_d = 1'b1;
            end
        end

        if ((state_q == RX) && !rx_if.rx_start && rx_if.eop && !stuff_hit) begin
            if (bit_cnt_d == '0) begin
                packet_done_d = 1'b1;
            end else begin
                align_err_d = 1'b1;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q     <= '0;
            sr_q          <= '0;
            rx_byte_q     <= '0;
            crc_clear_q   <= 1'b1;
            shift_q       <= 1'b0;
            serial_q      <= 1'b0;
            byte_valid_q  <= 1'b0;
            stuff_err_q   <= 1'b0;
            align_err_q   <= 1'b0;
            packet_done_q <= 1'b0;
        end else begin
            bit_cnt_q     <= bit_cnt_d;
            sr_q          <= sr_d;
            rx_byte_q     <= rx_byte_d;
            crc_clear_q   <= crc_clear_d;
            shift_q       <= shift_d;
            serial_q      <= serial_d;
            byte_valid_q  <= byte_valid_d;
            stuff_err_q   <= stuff_err_d;
            align_err_q   <= align_err_d;
            packet_done_q <= packet_done_d;
        end
    end

    assign rx_if.crc_clear        = crc_clear_q;
    assign rx_if.crc_shift_enable = shift_q;
    assign rx_if.crc_serial_in    = serial_q;
    assign rx_if.rx_byte          = rx_byte_q;
    assign rx_if.byte_valid       = byte_valid_q;
    assign rx_if.stuff_err        = stuff_err_q;
    assign rx_if.align_err        = align_err_q;
    assign rx_if.packet_done      = packet_done_q;

`ifdef USB_RX_BYTE_COUNT_EN
    logic [BCNT_W-1:0] byte_count_q, byte_count_d;

    // Per-packet byte count, saturating, held until the next accepted start
    always_comb begin
        byte_count_d = byte_count_q;
        if (start) begin
            byte_count_d = '0;
        end else if (byte_valid_d && (byte_count_q != '1)) begin
            byte_count_d = byte_count_q + 1'b1;
        end
    end

    // Byte count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_count_q <= '0;
        end else begin
            byte_count_q <= byte_count_d;
        end
    end

    assign rx_if.byte_count = byte_count_q;
`endif

endmodule

// File: tb/tb_usb_rx_unstuff_byte.sv
// Table-driven bench for usb_rx_unstuff_byte with a byte scoreboard.
module tb_usb_rx_unstuff_byte;
    import usb_rx_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    usb_rx_unstuff_byte_if rx_if ();

    usb_rx_unstuff_byte dut (
        .clk   (clk),
        .rst   (rst),
        .rx_if (rx_if)
    );

    typedef enum int {END_DONE, END_ALIGN, END_STUFF} end_t;

    typedef struct {
        string       name;
        logic [31:0] bits;    // bit i is the i-th bit on the wire
        int          nbits;
        int          nbytes;
        logic [7:0]  b0, b1, b2;
        int          nshift;
        logic [31:0] data;    // expected CRC serial stream, first bit in bit 0
        end_t        fin;
    } vec_t;

    vec_t vecs [8];

    int          vectors_applied = 0;
    int          miscompares     = 0;
    int          n_shift, n_bv, n_done, n_align, n_stuff;
    logic [31:0] cap;
    logic [7:0]  exp_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors_applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_counts();
        n_shift = 0; n_bv = 0; n_done = 0; n_align = 0; n_stuff = 0;
        cap = '0;
    endtask

    // Output monitor: collects CRC bits, scoreboards bytes, counts end pulses
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_if.crc_shift_enable) begin
                if (n_shift < 32) cap[n_shift] = rx_if.crc_serial_in;
                n_shift++;
            end
            if (rx_if.byte_valid) begin
                n_bv++;
                if (exp_q.size() == 0) begin
                    vectors_applied++;
                    miscompares++;
                    $display("FAIL byte_unexpected: got %02h expected none", rx_if.rx_byte);
                end else begin
                    chk("rx_byte", 32'(rx_if.rx_byte), 32'(exp_q.pop_front()));
                end
            end
            if (rx_if.packet_done) n_done++;
            if (rx_if.align_err)   n_align++;
            if (rx_if.stuff_err)   n_stuff++;
        end
    end

    task automatic send_bit(input logic b, input logic gap, input logic with_eop);
        @(negedge clk);
        rx_if.bit_valid = 1'b1;
        rx_if.d_in      = b;
        rx_if.eop       = with_eop;
        @(negedge clk);
        rx_if.bit_valid = 1'b0;
        rx_if.d_in      = 1'b0;
        rx_if.eop       = 1'b0;
        if (gap) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        rx_if.rx_start = 1'b1;
        @(negedge clk);
        rx_if.rx_start = 1'b0;
    endtask

    task automatic pulse_eop();
        @(negedge clk);
        rx_if.eop = 1'b1;
        @(negedge clk);
        rx_if.eop = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0, 1'b0);
    endtask

    task automatic apply(input int k);
        vec_t v;
        v = vecs[k];
        clear_counts();
        if (v.nbytes > 0) exp_q.push_back(v.b0);
        if (v.nbytes > 1) exp_q.push_back(v.b1);
        if (v.nbytes > 2) exp_q.push_back(v.b2);
        pulse_start();
        chk({v.name, "/crc_clear_rx"}, 32'(rx_if.crc_clear), 32'd0);
        for (int i = 0; i < v.nbits; i++) send_bit(v.bits[i], (i % 3) == 0, 1'b0);
        pulse_eop();
        repeat (3) @(negedge clk);
        chk({v.name, "/shifts"},   32'(n_shift), 32'(v.nshift));
        chk({v.name, "/crc_bits"}, cap, v.data);
        chk({v.name, "/bytes"},    32'(n_bv), 32'(v.nbytes));
        chk({v.name, "/done"},     32'(n_done),  (v.fin == END_DONE)  ? 32'd1 : 32'd0);
        chk({v.name, "/align"},    32'(n_align), (v.fin == END_ALIGN) ? 32'd1 : 32'd0);
        chk({v.name, "/stuff"},    32'(n_stuff), (v.fin == END_STUFF) ? 32'd1 : 32'd0);
        chk({v.name, "/sb_empty"}, 32'(exp_q.size()), 32'd0);
        chk({v.name, "/crc_clear_idle"}, 32'(rx_if.crc_clear), 32'd1);
        exp_q.delete();
    endtask

    initial begin
        rx_if.rx_start  = 1'b0;
        rx_if.bit_valid = 1'b0;
        rx_if.d_in      = 1'b0;
        rx_if.eop       = 1'b0;
        clear_counts();

        //           name       bits          nbits nbytes b0     b1     b2     nshift data          end
        vecs[0] = '{"a5",      32'h0000_00A5,  8,   1,    8'hA5, 8'h00, 8'h00,  8,    32'h0000_00A5, END_DONE};
        vecs[1] = '{"ff_stuff",32'h0000_01BF,  9,   1,    8'hFF, 8'h00, 8'h00,  8,    32'h0000_00FF, END_DONE};
        vecs[2] = '{"ones7",   32'h0000_017F,  9,   0,    8'h00, 8'h00, 8'h00,  6,    32'h0000_003F, END_STUFF};
        vecs[3] = '{"align",   32'h0000_063C, 12,   1,    8'h3C, 8'h00, 8'h00, 12,    32'h0000_063C, END_ALIGN};
        vecs[4] = '{"b12",     32'h0000_0012,  8,   1,    8'h12, 8'h00, 8'h00,  8,    32'h0000_0012, END_DONE};
        vecs[5] = '{"three",   32'h0067_A512, 24,   3,    8'h12, 8'hA5, 8'h67, 24,    32'h0067_A512, END_DONE};
        vecs[6] = '{"empty",   32'h0000_0000,  0,   0,    8'h00, 8'h00, 8'h00,  0,    32'h0000_0000, END_DONE};
        vecs[7] = '{"ffff",    32'h0003_DFBF, 18,   2,    8'hFF, 8'hFF, 8'h00, 16,    32'h0000_FFFF, END_DONE};

        repeat (3) @(negedge clk);
        chk("rst/crc_clear",   32'(rx_if.crc_clear), 32'd1);
        chk("rst/outputs",     32'({rx_if.crc_shift_enable, rx_if.crc_serial_in, rx_if.byte_valid,
                                    rx_if.stuff_err, rx_if.align_err, rx_if.packet_done}), 32'd0);
        chk("rst/rx_byte",     32'(rx_if.rx_byte), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 8; k++) apply(k);

        // Restart mid-packet: counters cleared, crc_clear pulses, no error
        clear_counts();
        exp_q.push_back(8'hA5);
        pulse_start();
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        pulse_start();
        chk("restart/crc_clear_pulse", 32'(rx_if.crc_clear), 32'd1);
        @(negedge clk);
        chk("restart/crc_clear_low", 32'(rx_if.crc_clear), 32'd0);
        send_byte(8'hA5);
        pulse_eop();
        repeat (3) @(negedge clk);
        chk("restart/shifts", 32'(n_shift), 32'd11);
        chk("restart/bytes",  32'(n_bv), 32'd1);
        chk("restart/done",   32'(n_done), 32'd1);
        chk("restart/errs",   32'(n_align + n_stuff), 32'd0);

        // Last bit and eop in the same cycle: bit counts before eop is judged
        clear_counts();
        exp_q.push_back(8'h12);
        pulse_start();
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk("eop_bit/bytes", 32'(n_bv), 32'd1);
        chk("eop_bit/done",  32'(n_done), 32'd1);
        chk("eop_bit/align", 32'(n_align), 32'd0);

        // Stuffing error then idle time: CRC stays frozen until eop
        clear_counts();
        pulse_start();
        for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("err/crc_frozen", 32'(rx_if.crc_clear), 32'd0);
        chk("err/stuff",      32'(n_stuff), 32'd1);
        pulse_eop();
        @(negedge clk);
        chk("err/idle_clear", 32'(rx_if.crc_clear), 32'd1);
        chk("err/no_done",    32'(n_done), 32'd0);

        // Reset mid-packet takes effect immediately
        clear_counts();
        pulse_start();
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid/crc_clear", 32'(rx_if.crc_clear), 32'd1);
        chk("rst_mid/rx_byte",   32'(rx_if.rx_byte), 32'd0);
        chk("rst_mid/pulses",    32'({rx_if.crc_shift_enable, rx_if.byte_valid, rx_if.stuff_err,
                                      rx_if.align_err, rx_if.packet_done}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        apply(4);

`ifdef USB_RX_BYTE_COUNT_EN
        apply(5);
        chk("bcnt/after_eop", 32'(rx_if.byte_count), 32'd3);
        pulse_start();
        chk("bcnt/after_start", 32'(rx_if.byte_count), 32'd0);
        pulse_eop();
        repeat (3) @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
